alu_regfile: RTL and testbench
==============================

# alu_regfile

Register file and flag holder that feeds the arithmetic unit and accepts its result in the single-cycle datapath. It supplies both ALU operands `a`/`b` combinationally from two read ports. On the clock edge it writes the ALU result `Aout` back to a destination register. It also latches the ALU `Zero` output into a persistent flag, but only for compare-type operations, and keeps a retired-write counter for debug.

## Interface
- `WL`, 32, data word width; matches the ALU operand width.
- `RL`, 5, register address width; the file holds 2**RL registers.
- `CL`, 16, retired-write counter width.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `rd_addr_a`  in  RL  read port A address.
- `rd_addr_b`  in  RL  read port B address.
- `a`  out  WL  operand A to the ALU, signed.
- `b`  out  WL  operand B to the ALU, signed.
- `wr_en`  in  1  write-back enable for this cycle.
- `wr_addr`  in  RL  destination register.
- `Aout`  in  WL  ALU result to write.
- `select`  in  3  ALU operation code for the current instruction.
- `Zero`  in  1  ALU zero output.
- `zero_flag`  out  1  latched compare result.
- `wr_count`  out  CL  number of accepted writes; wraps.

## Operation
- Storage: 2**RL registers of WL bits.
- Reads are combinational:
  - `a` = reg[`rd_addr_a`].
  - `b` = reg[`rd_addr_b`].
  - There is no read-during-write forwarding. `a`/`b` are never combinationally derived from `Aout`, because that would close a loop through the ALU.
- Write: on a rising `clk` with `wr_en`=1, reg[`wr_addr`] <= `Aout`. With `wr_en`=0 no register changes.
- Flag capture:
  - On a rising `clk` with `wr_en`=1 and `select` = 3'b001 or 3'b010 (a-b or b-a), `zero_flag` <= `Zero`.
  - For any other `select`, or with `wr_en`=0, `zero_flag` holds.
  - The ALU leaves `Zero` stale for non-subtract ops, so it must not be sampled for them.
- Counter:
  - `wr_count` increments by 1 on every edge where a write is accepted (`wr_en`=1 and the write is not suppressed; see Configuration).
  - It wraps from 2**CL-1 to 0 with no flag.
- Width rules: the write stores `Aout` verbatim; there is no sign extension or truncation inside the block. For `select`=3'b111 the ALU's product is already truncated to WL.
- Both read addresses may be equal; both ports then return the same value. Any read address may equal `wr_addr`.

## Timing
- Read latency: 0 cycles (combinational from the address and register state).
- Write latency: 1 edge. A value written at edge N is visible on `a`/`b` immediately after edge N.
- Read and write to the same address in the same cycle: the read returns the old value for the whole cycle, and the new value appears after the edge.
- Reset (asynchronous assert, takes effect without `clk`):
  - All registers go to 0.
  - `zero_flag` = 0.
  - `wr_count` = 0.
  - `a` = `b` = 0 as a consequence.
- Reset deasserted: the first write can occur on the first rising edge after deassertion.
- Reset mid-operation: any write pending on that edge is discarded, and the counter and flag clear.
- Back-to-back writes to the same register on consecutive edges: the last write wins, and each write counts.

## Configuration
- `RF_ZERO_REG_EN`
  - Defined: register 0 is hardwired to 0. Reads of address 0 return 0, and writes to `wr_addr`=0 are ignored and do not increment `wr_count`. Flag capture still occurs, so compare-and-discard into r0 is allowed.
  - Not defined: register 0 is an ordinary register, and writes to it count normally.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle after several writes -> all reads 0, `zero_flag`=0, `wr_count`=0 before the next edge.
- Write/read: write 32'h1234_5678 to r3 and 32'hFFFF_FFFE to r7, then read A=3, B=7 -> `a`=32'h1234_5678, `b`=-2 one edge later. In the same cycle as the r3 write, `a` still shows the old value 0.
- Flag capture:
  - `wr_en`=1, `select`=3'b001, `Zero`=1 -> `zero_flag`=1.
  - Next, `select`=3'b000, `Zero`=0 -> `zero_flag` stays 1.
  - Then `select`=3'b010, `Zero`=0 -> `zero_flag`=0.
- Counter wrap: with CL=4, perform 17 writes -> `wr_count`=1. Cycles with `wr_en`=0 leave it unchanged.
- r0 behaviour:
  - With `RF_ZERO_REG_EN`: write 32'hDEAD_BEEF to r0 -> read r0 = 0, `wr_count` unchanged.
  - Without it: read r0 = 32'hDEAD_BEEF, `wr_count` +1.
- Loop closure with the ALU: `rd_addr_a`=`wr_addr`=5, `select`=3'b011 (a+1), `wr_en`=1 for 4 edges from reset -> r5 = 4, no combinational oscillation.

Source files
------------

// File: rtl/alu_regfile.sv
// Register file, compare-flag holder and retired-write counter for the single-cycle ALU datapath.
// Optional feature: define RF_ZERO_REG_EN to hardwire register 0 to zero.
module alu_regfile #(
    parameter int WL = 32,
    parameter int RL = 5,
    parameter int CL = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [RL-1:0]        rd_addr_a,
    input  logic [RL-1:0]        rd_addr_b,
    output logic signed [WL-1:0] a,
    output logic signed [WL-1:0] b,
    input  logic                 wr_en,
    input  logic [RL-1:0]        wr_addr,
    input  logic [WL-1:0]        Aout,
    input  logic [2:0]           select,
    input  logic                 Zero,
    output logic                 zero_flag,
    output logic [CL-1:0]        wr_count
);

    localparam int NREGS = 1 << RL;

`ifdef RF_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [WL-1:0] regs_reg [NREGS];
    logic [RL-1:0] rd_addr  [2];
    logic [WL-1:0] rd_data  [2];
    logic          wr_accept;
    logic          flag_capture;

    // A write into a hardwired r0 is dropped entirely, including its count.
    assign wr_accept    = wr_en && !(ZERO_REG && (wr_addr == '0));
    // Zero is only meaningful after a subtract; other ops leave it stale.
    assign flag_capture = wr_en && ((select == 3'b001) || (select == 3'b010));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
            zero_flag <= 1'b0;
            wr_count  <= '0;
        end else begin
            if (wr_accept) begin
                regs_reg[wr_addr] <= Aout;
                wr_count          <= wr_count + CL'(1);
            end
            if (flag_capture) begin
                zero_flag <= Zero;
            end
        end
    end

    // Reads come straight from register state; never bypass Aout, which would loop through the ALU.
    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
            assign rd_data[gi] = (ZERO_REG && (rd_addr[gi] == '0)) ? '0 : regs_reg[rd_addr[gi]];
        end
    endgenerate

    assign a = rd_data[0];
    assign b = rd_data[1];

endmodule

// File: tb/tb_alu_regfile.sv
// Directed self-checking bench for alu_regfile; counter built 4 bits wide to reach the wrap.
module tb_alu_regfile;

    localparam int WL = 32;
    localparam int RL = 5;
    localparam int CL = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [RL-1:0]        rd_addr_a, rd_addr_b;
    logic signed [WL-1:0] a, b;
    logic                 wr_en;
    logic [RL-1:0]        wr_addr;
    logic [WL-1:0]        alu_aout;
    logic [WL-1:0]        aout_drv;
    logic                 alu_mode;
    logic [2:0]           select;
    logic                 Zero;
    logic                 zero_flag;
    logic [CL-1:0]        wr_count;

    int n_vec = 0;
    int n_err = 0;
    logic [CL-1:0] exp_cnt;

    // In ALU mode the bench acts as an a+1 unit feeding the write port.
    assign alu_aout = alu_mode ? (a + 32'd1) : aout_drv;

    alu_regfile #(.WL(WL), .RL(RL), .CL(CL)) dut (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .a(a), .b(b),
        .wr_en(wr_en), .wr_addr(wr_addr), .Aout(alu_aout),
        .select(select), .Zero(Zero),
        .zero_flag(zero_flag), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; aout_drv = '0; alu_mode = 1'b0;
        select = 3'b000; Zero = 1'b0; rd_addr_a = 5'd3; rd_addr_b = 5'd7;
        #12;
        n_vec++;
        if (a !== 32'sd0) begin n_err++; $display("FAIL reset_a: got %h want 0", a); end
        n_vec++;
        if (b !== 32'sd0) begin n_err++; $display("FAIL reset_b: got %h want 0", b); end
        n_vec++;
        if (zero_flag !== 1'b0) begin n_err++; $display("FAIL reset_flag: got %b want 0", zero_flag); end
        n_vec++;
        if (wr_count !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", wr_count); end
        tick();
        rst = 1'b0;
        exp_cnt = '0;
        $display("reset: a=%h b=%h flag=%b cnt=%0d", a, b, zero_flag, wr_count);
    endtask

    task automatic test_write_read();
        rd_addr_a = 5'd3; rd_addr_b = 5'd7;
        wr_en = 1'b1; wr_addr = 5'd3; aout_drv = 32'h1234_5678;
        #1;
        n_vec++;
        if (a !== 32'h0) begin n_err++; $display("FAIL same_cycle_old: got %h want 0", a); end
        tick(); exp_cnt++;
        n_vec++;
        if (a !== 32'h1234_5678) begin n_err++; $display("FAIL wr_r3: got %h want 12345678", a); end
        wr_addr = 5'd7; aout_drv = 32'hFFFF_FFFE;
        tick(); exp_cnt++;
        wr_en = 1'b0;
        n_vec++;
        if (b !== -32'sd2) begin n_err++; $display("FAIL wr_r7: got %0d want -2", b); end
        n_vec++;
        if (wr_count !== exp_cnt) begin n_err++; $display("FAIL wr_cnt: got %0d want %0d", wr_count, exp_cnt); end
        rd_addr_b = 5'd3;
        #1;
        n_vec++;
        if (b !== 32'h1234_5678) begin n_err++; $display("FAIL same_addr: got %h want 12345678", b); end
        rd_addr_b = 5'd7;
        $display("write_read: a=%h b=%h cnt=%0d", a, b, wr_count);
    endtask

    task automatic test_flag();
        wr_en = 1'b1; wr_addr = 5'd1; aout_drv = 32'h0;
        select = 3'b001; Zero = 1'b1;
        tick(); exp_cnt++;
        n_vec++;
        if (zero_flag !== 1'b1) begin n_err++; $display("FAIL flag_sub: got %b want 1", zero_flag); end
        select = 3'b000; Zero = 1'b0;
        tick(); exp_cnt++;
        n_vec++;
        if (zero_flag !== 1'b1) begin n_err++; $display("FAIL flag_hold_op: got %b want 1", zero_flag); end
        select = 3'b010; Zero = 1'b0;
        tick(); exp_cnt++;
        n_vec++;
        if (zero_flag !== 1'b0) begin n_err++; $display("FAIL flag_rsub: got %b want 0", zero_flag); end
        wr_en = 1'b0; select = 3'b001; Zero = 1'b1;
        tick();
        n_vec++;
        if (zero_flag !== 1'b0) begin n_err++; $display("FAIL flag_hold_noen: got %b want 0", zero_flag); end
        n_vec++;
        if (wr_count !== exp_cnt) begin n_err++; $display("FAIL flag_cnt: got %0d want %0d", wr_count, exp_cnt); end
        select = 3'b000; Zero = 1'b0;
        $display("flag: flag=%b cnt=%0d", zero_flag, wr_count);
    endtask

    task automatic test_async_reset();
        // Flag set so the clear is observable.
        wr_en = 1'b1; wr_addr = 5'd2; aout_drv = 32'h5; select = 3'b001; Zero = 1'b1;
        tick(); exp_cnt++;
        wr_en = 1'b0; select = 3'b000; Zero = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (a !== 32'sd0 || b !== 32'sd0) begin n_err++; $display("FAIL areset_rd: got a=%h b=%h want 0 0", a, b); end
        n_vec++;
        if (zero_flag !== 1'b0) begin n_err++; $display("FAIL areset_flag: got %b want 0", zero_flag); end
        n_vec++;
        if (wr_count !== 4'd0) begin n_err++; $display("FAIL areset_cnt: got %0d want 0", wr_count); end
        // A write presented while reset is held must be discarded.
        wr_en = 1'b1; wr_addr = 5'd3; aout_drv = 32'h77;
        tick();
        wr_en = 1'b0;
        rst = 1'b0;
        exp_cnt = '0;
        #1;
        n_vec++;
        if (a !== 32'sd0 || wr_count !== 4'd0) begin
            n_err++; $display("FAIL areset_pending: got a=%h cnt=%0d want 0 0", a, wr_count);
        end
        $display("async_reset: a=%h flag=%b cnt=%0d", a, zero_flag, wr_count);
    endtask

    task automatic test_counter_wrap();
        wr_en = 1'b1; wr_addr = 5'd2;
        for (int i = 0; i < 17; i++) begin
            aout_drv = 32'(i);
            tick(); exp_cnt++;
        end
        wr_en = 1'b0;
        n_vec++;
        if (wr_count !== 4'd1) begin n_err++; $display("FAIL cnt_wrap: got %0d want 1", wr_count); end
        repeat (3) tick();
        n_vec++;
        if (wr_count !== 4'd1) begin n_err++; $display("FAIL cnt_idle: got %0d want 1", wr_count); end
        rd_addr_a = 5'd2;
        #1;
        n_vec++;
        if (a !== 32'sd16) begin n_err++; $display("FAIL cnt_lastval: got %0d want 16", a); end
        $display("counter_wrap: cnt=%0d r2=%0d", wr_count, a);
    endtask

    task automatic test_r0();
        logic [WL-1:0] exp_r0;
        wr_en = 1'b1; wr_addr = 5'd0; aout_drv = 32'hDEAD_BEEF; rd_addr_a = 5'd0;
        tick();
        wr_en = 1'b0;
`ifdef RF_ZERO_REG_EN
        exp_r0 = 32'h0;
`else
        exp_r0 = 32'hDEAD_BEEF;
        exp_cnt++;
`endif
        n_vec++;
        if (a !== exp_r0) begin n_err++; $display("FAIL r0_read: got %h want %h", a, exp_r0); end
        n_vec++;
        if (wr_count !== exp_cnt) begin n_err++; $display("FAIL r0_cnt: got %0d want %0d", wr_count, exp_cnt); end
        $display("r0: a=%h cnt=%0d", a, wr_count);
    endtask

    task automatic test_back_to_back();
        rd_addr_a = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; aout_drv = 32'hAAAA_AAAA;
        tick(); exp_cnt++;
        aout_drv = 32'h5555_5555;
        tick(); exp_cnt++;
        wr_en = 1'b0;
        n_vec++;
        if (a !== 32'h5555_5555) begin n_err++; $display("FAIL b2b_val: got %h want 55555555", a); end
        n_vec++;
        if (wr_count !== exp_cnt) begin n_err++; $display("FAIL b2b_cnt: got %0d want %0d", wr_count, exp_cnt); end
        $display("back_to_back: a=%h cnt=%0d", a, wr_count);
    endtask

    task automatic test_alu_loop();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        rd_addr_a = 5'd5; wr_addr = 5'd5; select = 3'b011; alu_mode = 1'b1; wr_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_vec++;
            if (a !== 32'(i)) begin n_err++; $display("FAIL alu_loop_%0d: got %0d want %0d", i, a, i); end
        end
        wr_en = 1'b0; alu_mode = 1'b0; select = 3'b000;
        n_vec++;
        if (wr_count !== 4'd4) begin n_err++; $display("FAIL alu_loop_cnt: got %0d want 4", wr_count); end
        $display("alu_loop: r5=%0d cnt=%0d", a, wr_count);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_flag();
        test_async_reset();
        test_counter_wrap();
        test_r0();
        test_back_to_back();
        test_alu_loop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
